// File: rtl/ariane_pkg.sv
// ariane_pkg: shared issue types, operand register-file selectors and the writeback port default
package ariane_pkg;
  localparam int NR_WB_PORTS_DEF = 4;
  typedef enum logic [3:0] {
    ADD, SUB, LD, SD, FADD, FMUL, FMADD, FLD, FSD, FCVT_F2I, FCVT_I2F
  } fu_op;
  typedef struct packed {
    logic [31:0] pc;
    fu_op        op;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rd;
    logic [31:0] result;
  } scoreboard_entry_t;
  function automatic logic is_rs1_fpr(fu_op op);
    return op inside {FADD, FMUL, FMADD, FCVT_F2I};
  endfunction
  function automatic logic is_rs2_fpr(fu_op op);
    return op inside {FADD, FMUL, FMADD, FSD};
  endfunction
  function automatic logic is_rd_fpr(fu_op op);
    return op inside {FADD, FMUL, FMADD, FLD, FCVT_I2F};
  endfunction
  function automatic logic is_imm_fpr(fu_op op);
    return op == FMADD;
  endfunction
  function automatic logic is_x0(logic [5:0] name);
    return name[4:0] == 5'd0;
  endfunction
endpackage

// File: rtl/issue_busy_table_busy_table.sv
// busy_table: 64-entry busy bitmap with writeback clears, one set port and bypassed lookups
module busy_table import ariane_pkg::*; #(
  parameter int NR_PORTS  = 4,
  parameter int NR_LOOKUP = 4,
  parameter bit ZERO_X0   = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clr_all_i,
  input  logic                          set_i,
  input  logic [5:0]                    set_idx_i,
  input  logic                          kill_i,
  input  logic [5:0]                    kill_idx_i,
  input  logic [NR_PORTS-1:0]           wb_valid_i,
  input  logic [NR_PORTS-1:0][5:0]      wb_idx_i,
  input  logic [NR_LOOKUP-1:0][5:0]     lookup_idx_i,
  output logic [NR_LOOKUP-1:0]          busy_o
);
  logic [63:0] busy_q, busy_d, wb_clr;
  logic        set_ok;
  always_comb begin
    wb_clr = '0;
    for (int i = 0; i < NR_PORTS; i++)
      if (wb_valid_i[i]) wb_clr[wb_idx_i[i]] = 1'b1;
    set_ok = set_i && !(ZERO_X0 && is_x0(set_idx_i));
    busy_d = busy_q & ~wb_clr & ~(kill_i ? 64'(1) << kill_idx_i : 64'(0));
    busy_d = busy_d | (set_ok ? 64'(1) << set_idx_i : 64'(0));
    busy_o = '0;
    for (int k = 0; k < NR_LOOKUP; k++)
      busy_o[k] = busy_q[lookup_idx_i[k]] & ~wb_clr[lookup_idx_i[k]];
  end
  always_ff @(posedge clk_i)
    busy_q <= (rst_i || clr_all_i) ? '0 : busy_d;
endmodule

// File: rtl/issue_busy_table.sv
// issue_busy_table: RAW/WAW hazard check against GPR/FPR busy tables feeding a one-entry issue register
module issue_busy_table import ariane_pkg::*; #(
  parameter int NR_WB_PORTS = NR_WB_PORTS_DEF
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        flush_unissued_instr_i,
  input  scoreboard_entry_t           issue_instr_i,
  input  logic                        issue_instr_valid_i,
  output logic                        issue_ack_o,
  output scoreboard_entry_t           issue_instr_o,
  output logic                        issue_instr_valid_o,
  input  logic                        issue_ready_i,
  input  logic [NR_WB_PORTS-1:0]      wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][5:0] wb_rd_i,
  input  logic [NR_WB_PORTS-1:0]      wb_fpr_i
);
  logic [2:0] busy_gpr;
  logic [3:0] busy_fpr;
  logic       hazard, rd_fpr, held_rd_fpr, kill;
  assign rd_fpr      = is_rd_fpr(issue_instr_i.op);
  assign held_rd_fpr = is_rd_fpr(issue_instr_o.op);
  assign kill        = flush_unissued_instr_i & issue_instr_valid_o;
  always_comb begin
    hazard = (is_rs1_fpr(issue_instr_i.op) ? busy_fpr[0] : busy_gpr[0])
           | (is_rs2_fpr(issue_instr_i.op) ? busy_fpr[1] : busy_gpr[1])
           | (is_imm_fpr(issue_instr_i.op) & busy_fpr[2])
           | (rd_fpr ? busy_fpr[3] : busy_gpr[2]);
    issue_ack_o = !rst_i & issue_instr_valid_i & !hazard & (!issue_instr_valid_o | issue_ready_i)
                & !flush_i & !flush_unissued_instr_i;
  end
  busy_table #(.NR_PORTS(NR_WB_PORTS), .NR_LOOKUP(3), .ZERO_X0(1'b1)) u_gpr (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_all_i    (flush_i),
    .set_i        (issue_ack_o & !rd_fpr),
    .set_idx_i    (issue_instr_i.rd),
    .kill_i       (kill & !held_rd_fpr),
    .kill_idx_i   (issue_instr_o.rd),
    .wb_valid_i   (wb_valid_i & ~wb_fpr_i),
    .wb_idx_i     (wb_rd_i),
    .lookup_idx_i ({issue_instr_i.rd, issue_instr_i.rs2, issue_instr_i.rs1}),
    .busy_o       (busy_gpr)
  );
  busy_table #(.NR_PORTS(NR_WB_PORTS), .NR_LOOKUP(4), .ZERO_X0(1'b0)) u_fpr (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_all_i    (flush_i),
    .set_i        (issue_ack_o & rd_fpr),
    .set_idx_i    (issue_instr_i.rd),
    .kill_i       (kill & held_rd_fpr),
    .kill_idx_i   (issue_instr_o.rd),
    .wb_valid_i   (wb_valid_i & wb_fpr_i),
    .wb_idx_i     (wb_rd_i),
    .lookup_idx_i ({issue_instr_i.rd, issue_instr_i.result[5:0], issue_instr_i.rs2, issue_instr_i.rs1}),
    .busy_o       (busy_fpr)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issue_instr_valid_o <= 1'b0;
      issue_instr_o       <= '0;
    end else begin
      issue_instr_valid_o <= (flush_i || flush_unissued_instr_i) ? 1'b0 :
                             issue_ack_o ? 1'b1 : issue_ready_i ? 1'b0 : issue_instr_valid_o;
      if (issue_ack_o) issue_instr_o <= issue_instr_i;
    end
  end
endmodule

// File: tb/tb_issue_busy_table.sv
// tb_issue_busy_table: scoreboard bench with a small busy-table and output-register model
module tb_issue_busy_table;
  import ariane_pkg::*;
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic rst_i, flush_i, fun, vld, rdy, ack, vld_o;
  scoreboard_entry_t instr, instr_o;
  logic [3:0] wb_v, wb_f;
  logic [3:0][5:0] wb_rd;
  scoreboard_entry_t exp_q[$];
  scoreboard_entry_t e_ent;
  logic exp_vld;
  logic [63:0] exp_gpr, exp_fpr;
  int n_chk, n_err;
  issue_busy_table dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .flush_i                (flush_i),
    .flush_unissued_instr_i (fun),
    .issue_instr_i          (instr),
    .issue_instr_valid_i    (vld),
    .issue_ack_o            (ack),
    .issue_instr_o          (instr_o),
    .issue_instr_valid_o    (vld_o),
    .issue_ready_i          (rdy),
    .wb_valid_i             (wb_v),
    .wb_rd_i                (wb_rd),
    .wb_fpr_i               (wb_f)
  );
  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic scoreboard_entry_t mk(fu_op op, logic [5:0] rs1, logic [5:0] rs2, logic [5:0] rd, logic [5:0] rs3);
    scoreboard_entry_t s;
    s = '0;
    s.pc = $urandom;
    s.op = op;
    s.rs1 = rs1;
    s.rs2 = rs2;
    s.rd = rd;
    s.result = {$urandom_range(0, 1023), rs3};
    return s;
  endfunction
  task automatic idle();
    vld = 1'b0;
    rdy = 1'b1;
    flush_i = 1'b0;
    fun = 1'b0;
    wb_v = '0;
    wb_f = '0;
    wb_rd = '0;
    instr = '0;
  endtask
  task automatic cyc(string tag, logic exp_ack);
    scoreboard_entry_t h;
    logic [63:0] g, f;
    @(negedge clk_i);
    check({tag, "_ack"}, ack, exp_ack);
    check({tag, "_vld"}, vld_o, exp_vld);
    check({tag, "_gpr"}, dut.u_gpr.busy_q, exp_gpr);
    check({tag, "_fpr"}, dut.u_fpr.busy_q, exp_fpr);
    g = exp_gpr;
    f = exp_fpr;
    if (rst_i) begin
      exp_q.delete();
      exp_vld = 1'b0;
      g = '0;
      f = '0;
    end else begin
      if (exp_vld && (rdy || flush_i || fun)) begin
        h = exp_q.pop_front();
        if (fun) begin
          if (is_rd_fpr(h.op)) f[h.rd] = 1'b0;
          else g[h.rd] = 1'b0;
        end else if (!flush_i) check({tag, "_out"}, instr_o, h);
      end
      for (int p = 0; p < 4; p++)
        if (wb_v[p]) begin
          if (wb_f[p]) f[wb_rd[p]] = 1'b0;
          else g[wb_rd[p]] = 1'b0;
        end
      if (exp_ack) begin
        if (is_rd_fpr(instr.op)) f[instr.rd] = 1'b1;
        else if (instr.rd[4:0] != 5'd0) g[instr.rd] = 1'b1;
        exp_q.push_back(instr);
      end
      if (flush_i) begin
        g = '0;
        f = '0;
      end
      exp_vld = (flush_i || fun) ? 1'b0 : exp_ack ? 1'b1 : rdy ? 1'b0 : exp_vld;
    end
    exp_gpr = g;
    exp_fpr = f;
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    n_chk = 0;
    n_err = 0;
    exp_vld = 1'b0;
    exp_gpr = '0;
    exp_fpr = '0;
    idle();
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    instr = mk(ADD, 6'd0, 6'd0, 6'd1, 6'd0);
    vld = 1'b1;
    cyc("rst", 1'b0);
    rst_i = 1'b0;
    check("rst_out", instr_o, '0);
    idle();
    instr = mk(ADD, 6'd0, 6'd0, 6'h05, 6'd0);
    vld = 1'b1;
    cyc("s1_a", 1'b1);
    instr = mk(ADD, 6'h05, 6'd0, 6'h06, 6'd0);
    cyc("s1_raw0", 1'b0);
    cyc("s1_raw1", 1'b0);
    wb_v[0] = 1'b1;
    wb_rd[0] = 6'h05;
    cyc("s1_byp", 1'b1);
    idle();
    wb_v[1] = 1'b1;
    wb_rd[1] = 6'h06;
    cyc("s1_clr", 1'b0);
    idle();
    vld = 1'b1;
    instr = mk(ADD, 6'h00, 6'd0, 6'h00, 6'd0);
    cyc("s2_x0", 1'b1);
    instr = mk(ADD, 6'h00, 6'd0, 6'h20, 6'd0);
    cyc("s2_x32", 1'b1);
    idle();
    cyc("s2_drain", 1'b0);
    check("s2_gpr_zero", dut.u_gpr.busy_q, 64'h0);
    e_ent = mk(ADD, 6'd0, 6'd0, 6'h07, 6'd0);
    instr = e_ent;
    vld = 1'b1;
    cyc("s3_e", 1'b1);
    rdy = 1'b0;
    instr = mk(ADD, 6'd0, 6'd0, 6'h08, 6'd0);
    for (int i = 0; i < 3; i++) begin
      cyc("s3_stall", 1'b0);
      check("s3_hold", instr_o, e_ent);
    end
    rdy = 1'b1;
    cyc("s3_go", 1'b1);
    idle();
    wb_v = 4'b1100;
    wb_rd[2] = 6'h07;
    wb_rd[3] = 6'h08;
    cyc("s3_clr", 1'b0);
    idle();
    instr = mk(FADD, 6'd0, 6'd0, 6'h27, 6'd0);
    vld = 1'b1;
    cyc("s4_g", 1'b1);
    instr = mk(ADD, 6'd0, 6'd0, 6'h09, 6'd0);
    rdy = 1'b0;
    fun = 1'b1;
    cyc("s4_kill", 1'b0);
    idle();
    cyc("s4_after", 1'b0);
    check("s4_fpr27", dut.u_fpr.busy_q[6'h27], 1'b0);
    instr = mk(FLD, 6'd0, 6'd0, 6'h03, 6'd0);
    vld = 1'b1;
    cyc("r3_ld", 1'b1);
    instr = mk(FMADD, 6'd0, 6'd0, 6'h04, 6'h03);
    cyc("r3_raw", 1'b0);
    wb_v[0] = 1'b1;
    wb_rd[0] = 6'h03;
    cyc("r3_gprwb", 1'b0);
    wb_f[0] = 1'b1;
    cyc("r3_fprwb", 1'b1);
    wb_v = '0;
    wb_f = '0;
    instr = mk(FADD, 6'd0, 6'd0, 6'h04, 6'd0);
    cyc("waw", 1'b0);
    wb_v[1] = 1'b1;
    wb_f[1] = 1'b1;
    wb_rd[1] = 6'h04;
    cyc("waw_byp", 1'b1);
    vld = 1'b0;
    check("set_wins", dut.u_fpr.busy_q[6'h04], 1'b1);
    cyc("waw_clr", 1'b0);
    idle();
    vld = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      instr = mk((i % 2) ? ADD : FLD, 6'd0, 6'd0, 6'(i), 6'd0);
      cyc("s5_set", 1'b1);
    end
    instr = mk(ADD, 6'd0, 6'd0, 6'h0b, 6'd0);
    flush_i = 1'b1;
    cyc("s5_flush", 1'b0);
    idle();
    check("s5_gpr", dut.u_gpr.busy_q, 64'h0);
    check("s5_fpr", dut.u_fpr.busy_q, 64'h0);
    cyc("s5_after", 1'b0);
    instr = mk(ADD, 6'd0, 6'd0, 6'h0c, 6'd0);
    vld = 1'b1;
    cyc("s6_i", 1'b1);
    rdy = 1'b0;
    rst_i = 1'b1;
    instr = mk(FADD, 6'd0, 6'd0, 6'h0d, 6'd0);
    wb_v[2] = 1'b1;
    cyc("s6_rst", 1'b0);
    rst_i = 1'b0;
    idle();
    check("s6_out", instr_o, '0);
    check("s6_vld", vld_o, 1'b0);
    instr = mk(ADD, 6'd0, 6'd0, 6'h0c, 6'd0);
    vld = 1'b1;
    cyc("s6_again", 1'b1);
    idle();
    cyc("end0", 1'b0);
    cyc("end1", 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
